// File: rtl/adc_pkg.sv
// Shared types and constants for the parallel-output ADC emulator.
package adc_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CONV_CYCLES_DEF = 60;
  localparam int unsigned CNT_W           = 10;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StReady
  } adc_state_e;

endpackage

// File: rtl/adc_parallel_emulator_if.sv
// Pin-level bus between an ADC controller (master) and the emulated converter (slave).
interface adc_parallel_emulator_if;
  import adc_pkg::*;

  logic              CONVST;
  logic              CS;
  logic              RD;
  logic              EOC;
  logic [DATA_W-1:0] Data;
  logic              Data_oe;

  modport master (output CONVST, CS, RD, input EOC, Data, Data_oe);
  modport slave  (input CONVST, CS, RD, output EOC, Data, Data_oe);

endinterface

// File: rtl/adc_edge_sync.sv
// Registers the controller strobes once; flags CONVST falling edges and active reads.
module adc_edge_sync (
  input  logic clk_100M,
  input  logic reset,
  input  logic convst_i,
  input  logic cs_i,
  input  logic rd_i,
  output logic conv_fall_o,
  output logic read_active_o
);

  logic cnv_q, cs_q, rd_q;

  // cnv_q resets low so a CONVST held low across reset release is not taken as an edge.
  always_ff @(posedge clk_100M or negedge reset) begin
    if (!reset) begin
      cnv_q <= 1'b0;
      cs_q  <= 1'b1;
      rd_q  <= 1'b1;
    end else begin
      cnv_q <= convst_i;
      cs_q  <= cs_i;
      rd_q  <= rd_i;
    end
  end

  assign conv_fall_o   = cnv_q & ~convst_i;
  assign read_active_o = ~cs_q & ~rd_q;

endmodule

// File: rtl/adc_parallel_emulator.sv
// Emulated 8-bit parallel ADC: CONVST-triggered conversion, EOC handshake, timed read bus.
module adc_parallel_emulator
  import adc_pkg::*;
#(
  parameter int unsigned       CONV_CYCLES      = CONV_CYCLES_DEF,
  parameter int unsigned       RD_ACCESS_CYCLES = 2,
  parameter logic [DATA_W-1:0] RAMP_STEP        = 8'd1
) (
  input  logic                    clk_100M,
  input  logic                    reset,
  adc_parallel_emulator_if.slave  adc_bus,
  input  logic                    src_sel,
  input  logic [DATA_W-1:0]       ext_sample,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             conv_count
);

  localparam logic [CNT_W-1:0] ConvLoad  = CNT_W'(CONV_CYCLES - 1);
  localparam logic [1:0]       AccTarget = 2'(RD_ACCESS_CYCLES);

  logic conv_fall, read_active;

  adc_edge_sync u_edge_sync (
    .clk_100M      (clk_100M),
    .reset         (reset),
    .convst_i      (adc_bus.CONVST),
    .cs_i          (adc_bus.CS),
    .rd_i          (adc_bus.RD),
    .conv_fall_o   (conv_fall),
    .read_active_o (read_active)
  );

  adc_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] held_q, data_q, ramp_q;
  logic              eoc_q, busy_q, overrun_q;
  logic [15:0]       count_q;
  logic [1:0]        acc_q;
  logic [DATA_W-1:0] sample;

  assign sample = src_sel ? ext_sample : ramp_q;

  always_ff @(posedge clk_100M or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      held_q    <= '0;
      data_q    <= '0;
      ramp_q    <= '0;
      eoc_q     <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      acc_q     <= '0;
    end else begin
      overrun_q <= 1'b0;
      // Access counter saturates; it only needs to reach the largest legal access time.
      if (read_active) begin
        if (acc_q != 2'd3) acc_q <= acc_q + 2'd1;
      end else begin
        acc_q <= '0;
      end

      case (state_q)
        StIdle: begin
          if (conv_fall) begin
            held_q  <= sample;
            cnt_q   <= ConvLoad;
            busy_q  <= 1'b1;
            state_q <= StConv;
          end
        end
        StConv: begin
          if (conv_fall) overrun_q <= 1'b1;
          if (cnt_q == '0) begin
            data_q  <= held_q;
            eoc_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= count_q + 16'd1;
            ramp_q  <= ramp_q + RAMP_STEP;
            state_q <= StReady;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StReady: begin
          // A new start beats a coincident read; data_q keeps the unread sample meanwhile.
          if (conv_fall) begin
            eoc_q     <= 1'b1;
            held_q    <= sample;
            cnt_q     <= ConvLoad;
            busy_q    <= 1'b1;
            overrun_q <= 1'b1;
            state_q   <= StConv;
          end else if (read_active) begin
            eoc_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign adc_bus.EOC     = eoc_q;
  assign adc_bus.Data_oe = read_active && (acc_q >= AccTarget);
  assign adc_bus.Data    = adc_bus.Data_oe ? data_q : '0;
  assign busy            = busy_q;
  assign overrun         = overrun_q;
  assign conv_count      = count_q;

endmodule
